// File: rtl/uart_reg_bank.sv
// CPU-facing UART register bank: one addressed array with per-bit
// RW / RO / read-to-clear / write-one-to-clear behaviour and peripheral load/set.
module uart_reg_bank #(
  parameter int NUM_REGS   = 4,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 2,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RW_PATTERN  = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RC_PATTERN  = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] W1C_PATTERN = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr_i,
  input  logic                          cpu_wr_en_i,
  input  logic                          cpu_rd_en_i,
  input  logic [REG_WIDTH-1:0]          cpu_wdata_i,
  output logic [REG_WIDTH-1:0]          cpu_rdata_o,
  output logic                          cpu_rvalid_o,
  output logic                          cpu_err_o,
  input  logic [NUM_REGS-1:0]           periph_wr_en_i,
  input  logic [NUM_REGS*REG_WIDTH-1:0] periph_data_i,
  input  logic [NUM_REGS*REG_WIDTH-1:0] periph_set_i,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o
);

  localparam int TOT = NUM_REGS * REG_WIDTH;

  logic [TOT-1:0]       r_regs;
  logic [TOT-1:0]       w_next;
  logic [REG_WIDTH-1:0] r_rdata;
  logic                 r_rvalid;
  logic                 r_err;
  logic                 w_in_range;
  logic [REG_WIDTH-1:0] w_rsel;
  logic [REG_WIDTH-1:0] w_cur;
  logic [REG_WIDTH-1:0] w_nxt;
  logic [REG_WIDTH-1:0] w_rw;
  logic [REG_WIDTH-1:0] w_w1c;
  logic                 w_wr;
  logic                 w_rd;

  assign w_in_range = {1'b0, cpu_addr_i} < (ADDR_WIDTH+1)'(NUM_REGS);

  always_comb begin
    w_rsel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cpu_addr_i == ADDR_WIDTH'(k))
        w_rsel = r_regs[k*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Lowest priority applied first, each later step overrides the earlier one.
  always_comb begin
    w_next = r_regs;
    w_cur  = '0;
    w_nxt  = '0;
    w_rw   = '0;
    w_w1c  = '0;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_cur = r_regs[k*REG_WIDTH +: REG_WIDTH];
      w_w1c = W1C_PATTERN[k*REG_WIDTH +: REG_WIDTH];
      w_rw  = RW_PATTERN[k*REG_WIDTH +: REG_WIDTH] & ~w_w1c;
      w_wr  = cpu_wr_en_i && w_in_range && (cpu_addr_i == ADDR_WIDTH'(k));
      w_rd  = cpu_rd_en_i && w_in_range && (cpu_addr_i == ADDR_WIDTH'(k));
      w_nxt = w_cur;
      if (w_rd && !w_wr)
        w_nxt = w_nxt & ~RC_PATTERN[k*REG_WIDTH +: REG_WIDTH];
      if (periph_wr_en_i[k])
        w_nxt = periph_data_i[k*REG_WIDTH +: REG_WIDTH];
      if (w_wr) begin
        w_nxt = (w_nxt & ~w_rw) | (cpu_wdata_i & w_rw);
        w_nxt = (w_nxt & ~w_w1c) | (w_cur & ~cpu_wdata_i & w_w1c);
      end
      w_nxt = w_nxt | periph_set_i[k*REG_WIDTH +: REG_WIDTH];
      w_next[k*REG_WIDTH +: REG_WIDTH] = w_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_regs   <= RESET_VALUE;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_regs   <= w_next;
      r_rvalid <= cpu_rd_en_i;
      r_err    <= (cpu_rd_en_i || cpu_wr_en_i) && !w_in_range;
      if (cpu_rd_en_i)
        r_rdata <= w_in_range ? w_rsel : '0;
    end
  end

  assign regs_o       = r_regs;
  assign cpu_rdata_o  = r_rdata;
  assign cpu_rvalid_o = r_rvalid;
  assign cpu_err_o    = r_err;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed self-checking bench for uart_reg_bank: a 4-register bank with
// mixed bit types and a 3-register bank for out-of-range accesses.
module tb_uart_reg_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   a_addr;
  logic         a_wr, a_rd;
  logic [31:0]  a_wdata, a_rdata;
  logic         a_rvalid, a_err;
  logic [3:0]   a_pwr;
  logic [127:0] a_pdata, a_pset, a_regs;

  logic [1:0]   b_addr;
  logic         b_wr, b_rd;
  logic [31:0]  b_wdata, b_rdata;
  logic         b_rvalid, b_err;
  logic [2:0]   b_pwr;
  logic [95:0]  b_pdata, b_pset, b_regs;

  int n_chk = 0;
  int n_fail = 0;

  uart_reg_bank #(
    .NUM_REGS(4), .REG_WIDTH(32), .ADDR_WIDTH(2),
    .RW_PATTERN ({32'h0, 32'h0, 32'h0, 32'hFF}),
    .RC_PATTERN ({32'h0, 32'h1, 32'h0, 32'h0}),
    .W1C_PATTERN({32'hF, 32'h0, 32'h0, 32'h0}),
    .RESET_VALUE({32'h0, 32'h0, 32'hA5, 32'h0})
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(a_addr), .cpu_wr_en_i(a_wr), .cpu_rd_en_i(a_rd),
    .cpu_wdata_i(a_wdata), .cpu_rdata_o(a_rdata),
    .cpu_rvalid_o(a_rvalid), .cpu_err_o(a_err),
    .periph_wr_en_i(a_pwr), .periph_data_i(a_pdata),
    .periph_set_i(a_pset), .regs_o(a_regs)
  );

  uart_reg_bank #(
    .NUM_REGS(3), .REG_WIDTH(32), .ADDR_WIDTH(2),
    .RW_PATTERN ({32'h0, 32'h0, 32'hFFFF_FFFF}),
    .RC_PATTERN ('0),
    .W1C_PATTERN('0),
    .RESET_VALUE({32'h33, 32'h22, 32'h11})
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(b_addr), .cpu_wr_en_i(b_wr), .cpu_rd_en_i(b_rd),
    .cpu_wdata_i(b_wdata), .cpu_rdata_o(b_rdata),
    .cpu_rvalid_o(b_rvalid), .cpu_err_o(b_err),
    .periph_wr_en_i(b_pwr), .periph_data_i(b_pdata),
    .periph_set_i(b_pset), .regs_o(b_regs)
  );

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_wr = 0; a_rd = 0; a_pwr = '0; a_pset = '0;
    b_wr = 0; b_rd = 0; b_pwr = '0; b_pset = '0;
  endtask

  initial begin
    a_addr = '0; a_wdata = '0; a_pdata = '0;
    b_addr = '0; b_wdata = '0; b_pdata = '0;
    idle();

    tick();
    check_eq("rst_reg0", a_regs[31:0], 32'h0);
    check_eq("rst_reg1", a_regs[63:32], 32'hA5);
    check_eq("rst_rdata", a_rdata, 32'h0);
    check_eq("rst_rvalid", 32'(a_rvalid), 32'h0);
    check_eq("rst_err", 32'(a_err), 32'h0);
    rst = 0;

    a_wr = 1; a_addr = 2'd0; a_wdata = 32'hFFFF_FFFF;
    tick(); idle();
    check_eq("rw_mask", a_regs[31:0], 32'hFF);

    a_rd = 1; a_addr = 2'd0;
    tick(); idle();
    check_eq("rd_rvalid", 32'(a_rvalid), 32'h1);
    check_eq("rd_rdata", a_rdata, 32'hFF);
    tick();
    check_eq("rd_rvalid_low", 32'(a_rvalid), 32'h0);
    check_eq("rd_rdata_hold", a_rdata, 32'hFF);

    a_pset[64] = 1'b1;
    tick(); idle();
    check_eq("rc_set", a_regs[95:64], 32'h1);
    a_rd = 1; a_addr = 2'd2;
    tick(); idle();
    check_eq("rc_rdata", a_rdata, 32'h1);
    check_eq("rc_cleared", a_regs[95:64], 32'h0);

    a_pset[64] = 1'b1;
    tick();
    a_rd = 1; a_addr = 2'd2;
    tick(); idle();
    check_eq("rcset_rdata", a_rdata, 32'h1);
    check_eq("rcset_kept", a_regs[95:64], 32'h1);

    a_rd = 1; a_addr = 2'd2;
    tick();
    check_eq("b2b_rvalid1", 32'(a_rvalid), 32'h1);
    check_eq("b2b_rdata1", a_rdata, 32'h1);
    tick(); idle();
    check_eq("b2b_rvalid2", 32'(a_rvalid), 32'h1);
    check_eq("b2b_rdata2", a_rdata, 32'h0);

    a_pset[127:96] = 32'hF;
    tick(); idle();
    check_eq("w1c_init", a_regs[127:96], 32'hF);
    a_wr = 1; a_addr = 2'd3; a_wdata = 32'h5;
    tick(); idle();
    check_eq("w1c_clear", a_regs[127:96], 32'hA);
    a_wr = 1; a_addr = 2'd3; a_wdata = 32'h2; a_pset[97] = 1'b1;
    tick(); idle();
    check_eq("w1c_vs_set", a_regs[127:96], 32'hA);

    a_pwr[0] = 1'b1; a_pdata[31:0] = 32'hABCD_0011;
    a_wr = 1; a_addr = 2'd0; a_wdata = 32'h22;
    tick(); idle();
    check_eq("prio_cpu_periph", a_regs[31:0], 32'hABCD_0022);

    a_wr = 1; a_rd = 1; a_addr = 2'd0; a_wdata = 32'h33;
    tick(); idle();
    check_eq("wr_rd_rdata", a_rdata, 32'hABCD_0022);
    check_eq("wr_rd_reg", a_regs[31:0], 32'hABCD_0033);

    a_pset[64] = 1'b1;
    tick(); idle();
    a_wr = 1; a_rd = 1; a_addr = 2'd2; a_wdata = 32'h0;
    tick(); idle();
    check_eq("wr_rd_rdata2", a_rdata, 32'h1);
    check_eq("wr_rd_no_rc", a_regs[95:64], 32'h1);

    a_pwr[1] = 1'b1; a_pdata[63:32] = 32'h1234;
    tick(); idle();
    check_eq("periph_load", a_regs[63:32], 32'h1234);
    a_rd = 1; a_addr = 2'd1;
    tick(); idle();
    check_eq("pre_rst_rvalid", 32'(a_rvalid), 32'h1);
    #2 rst = 1;
    #1;
    check_eq("async_reg1", a_regs[63:32], 32'hA5);
    check_eq("async_reg0", a_regs[31:0], 32'h0);
    check_eq("async_rvalid", 32'(a_rvalid), 32'h0);
    check_eq("async_rdata", a_rdata, 32'h0);
    check_eq("async_err", 32'(a_err), 32'h0);
    rst = 0;
    tick();

    b_rd = 1; b_addr = 2'd2;
    tick(); idle();
    check_eq("b_rd_rdata", b_rdata, 32'h33);
    check_eq("b_rd_err", 32'(b_err), 32'h0);
    b_rd = 1; b_addr = 2'd3;
    tick(); idle();
    check_eq("oor_rd_rdata", b_rdata, 32'h0);
    check_eq("oor_rd_rvalid", 32'(b_rvalid), 32'h1);
    check_eq("oor_rd_err", 32'(b_err), 32'h1);
    tick();
    check_eq("oor_err_pulse", 32'(b_err), 32'h0);
    b_wr = 1; b_addr = 2'd3; b_wdata = 32'hFFFF_FFFF;
    tick(); idle();
    check_eq("oor_wr_err", 32'(b_err), 32'h1);
    check_eq("oor_wr_rvalid", 32'(b_rvalid), 32'h0);
    check_eq("oor_reg0", b_regs[31:0], 32'h11);
    check_eq("oor_reg1", b_regs[63:32], 32'h22);
    check_eq("oor_reg2", b_regs[95:64], 32'h33);
    tick();
    check_eq("oor_wr_err_low", 32'(b_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
